external_irq_arbiter: RTL and testbench

Collects the platform's external interrupt request lines, latches rising edges into per-line pending bits, and selects one pending line at a time by round-robin. It presents the selected line on the core's external interrupt handshake (EXT_ACTIVE / EXT_NUM / EXT_ACK) directly upstream of interrupt_control. Line index is sent raw; interrupt_control applies the +4 vector offset.

---
 rtl/core_irq_pkg.sv | 16 +
 rtl/rr_priority_select.sv | 38 +++
 rtl/external_irq_arbiter.sv | 148 ++++++++++++++
 tb/tb_external_irq_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_irq_pkg.sv
// Shared definitions for the core external-interrupt path.
// Holds the arbiter state encoding and the EXT_NUM handshake limits
// shared by external_irq_arbiter and interrupt_control.
package core_irq_pkg;

    localparam int unsigned EXT_IRQ_NUM_W       = 6;
    localparam int unsigned EXT_IRQ_VECT_OFFSET = 4;
    localparam int unsigned EXT_IRQ_MAX_LINES   = 60;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } irq_arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority search over a request vector.
// Ports:
//   pending  : request vector to search
//   ptr      : index where the ascending search starts (must be < WIDTH)
//   found_c  : at least one bit of pending is set
//   idx_c    : first set index at or after ptr, wrapping WIDTH-1 -> 0
module rr_priority_select #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] pending,
    input  logic [IDX_W-1:0] ptr,
    output logic             found_c,
    output logic [IDX_W-1:0] idx_c
);

    logic [WIDTH-1:0] rot_c;
    logic [IDX_W:0]   sum_c;

    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        rot_c   = WIDTH'({pending, pending} >> ptr);
        found_c = 1'b0;
        sum_c   = '0;
        for (int j = int'(WIDTH) - 1; j >= 0; j--) begin
            if (rot_c[j]) begin
                found_c = 1'b1;
                sum_c   = (IDX_W+1)'(ptr) + (IDX_W+1)'(j);
            end
        end
        if (sum_c >= (IDX_W+1)'(WIDTH)) begin
            idx_c = IDX_W'(sum_c - (IDX_W+1)'(WIDTH));
        end else begin
            idx_c = IDX_W'(sum_c);
        end
    end

endmodule

// File: rtl/external_irq_arbiter.sv
// External interrupt arbiter: latches rising edges of the request lines into
// pending bits and presents one pending line at a time, round-robin, on the
// EXT_ACTIVE / EXT_NUM / EXT_ACK handshake to interrupt_control.
// Ports:
//   iCLOCK       : core clock
//   iRESET_SYNC  : synchronous active-high reset
//   iARB_ENABLE  : allows new presentations to start
//   iIRQ_REQ     : request lines, synchronous to iCLOCK
//   oEXT_ACTIVE  : a line is being presented
//   oEXT_NUM     : presented line index (raw, no vector offset)
//   iEXT_ACK     : one-cycle acceptance pulse
//   oPENDING     : pending bit vector (status)
module external_irq_arbiter
    import core_irq_pkg::*;
#(
    parameter int unsigned IRQ_LINES  = 32,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                     iCLOCK,
    input  logic                     iRESET_SYNC,
    input  logic                     iARB_ENABLE,
    input  logic [IRQ_LINES-1:0]     iIRQ_REQ,
    output logic                     oEXT_ACTIVE,
    output logic [EXT_IRQ_NUM_W-1:0] oEXT_NUM,
    input  logic                     iEXT_ACK,
    output logic [IRQ_LINES-1:0]     oPENDING
);

    localparam int unsigned IDX_W = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1;
    localparam int unsigned GAP_W = 4;

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_PRESENT = PRESENT;
    localparam logic [1:0] S_GAP     = GAP;

    // Parameter legality: index plus vector offset must fit EXT_NUM.
    if (IRQ_LINES == 0 || IRQ_LINES > EXT_IRQ_MAX_LINES ||
        IRQ_LINES + EXT_IRQ_VECT_OFFSET > 2**EXT_IRQ_NUM_W) begin : g_bad_lines
        $error("external_irq_arbiter: IRQ_LINES out of range");
    end
    if (GAP_CYCLES == 0 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("external_irq_arbiter: GAP_CYCLES out of range");
    end

    logic [IRQ_LINES-1:0]     req_d;
    logic [IRQ_LINES-1:0]     pending;
    logic [IRQ_LINES-1:0]     pending_nxt_c;
    logic [IRQ_LINES-1:0]     clr_c;
    logic [IDX_W-1:0]         ptr;
    logic [IDX_W-1:0]         ptr_nxt_c;
    logic [1:0]               state;
    logic [1:0]               state_nxt_c;
    logic [GAP_W-1:0]         gap_cnt;
    logic [GAP_W-1:0]         gap_nxt_c;
    logic                     active_nxt_c;
    logic [EXT_IRQ_NUM_W-1:0] num_nxt_c;
    logic                     ack_c;
    logic                     sel_found_c;
    logic [IDX_W-1:0]         sel_idx_c;

    rr_priority_select #(
        .WIDTH (IRQ_LINES),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .pending (pending),
        .ptr     (ptr),
        .found_c (sel_found_c),
        .idx_c   (sel_idx_c)
    );

    // ACK only counts while a line is being presented.
    assign ack_c = (state == S_PRESENT) && iEXT_ACK;

    // Clear the presented line on ACK; a same-cycle rising edge wins.
    always_comb begin
        clr_c         = ack_c ? (IRQ_LINES'(1) << oEXT_NUM) : '0;
        pending_nxt_c = (pending & ~clr_c) | (iIRQ_REQ & ~req_d);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt_c  = state;
        active_nxt_c = oEXT_ACTIVE;
        num_nxt_c    = oEXT_NUM;
        ptr_nxt_c    = ptr;
        gap_nxt_c    = gap_cnt;
        case (state)
            S_IDLE: begin
                active_nxt_c = 1'b0;
                if (iARB_ENABLE && sel_found_c) begin
                    num_nxt_c    = EXT_IRQ_NUM_W'(sel_idx_c);
                    active_nxt_c = 1'b1;
                    state_nxt_c  = S_PRESENT;
                end
            end
            S_PRESENT: begin
                active_nxt_c = 1'b1;
                if (ack_c) begin
                    active_nxt_c = 1'b0;
                    gap_nxt_c    = GAP_W'(GAP_CYCLES);
                    state_nxt_c  = S_GAP;
                    if (32'(oEXT_NUM) + 32'd1 >= IRQ_LINES) begin
                        ptr_nxt_c = '0;
                    end else begin
                        ptr_nxt_c = IDX_W'(32'(oEXT_NUM) + 32'd1);
                    end
                end
            end
            S_GAP: begin
                // Hold ACTIVE low so interrupt_control cannot re-capture it.
                active_nxt_c = 1'b0;
                gap_nxt_c    = gap_cnt - GAP_W'(1);
                if (gap_cnt <= GAP_W'(1)) begin
                    gap_nxt_c   = '0;
                    state_nxt_c = S_IDLE;
                end
            end
            default: begin
                active_nxt_c = 1'b0;
                state_nxt_c  = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state       <= S_IDLE;
            req_d       <= '0;
            pending     <= '0;
            ptr         <= '0;
            gap_cnt     <= '0;
            oEXT_ACTIVE <= 1'b0;
            oEXT_NUM    <= '0;
        end else begin
            state       <= state_nxt_c;
            req_d       <= iIRQ_REQ;
            pending     <= pending_nxt_c;
            ptr         <= ptr_nxt_c;
            gap_cnt     <= gap_nxt_c;
            oEXT_ACTIVE <= active_nxt_c;
            oEXT_NUM    <= num_nxt_c;
        end
    end

    assign oPENDING = pending;

endmodule

// File: tb/tb_external_irq_arbiter.sv
// Directed bench for external_irq_arbiter (IRQ_LINES=32, GAP_CYCLES=2).
module tb_external_irq_arbiter;

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC = 1'b1;
    logic        iARB_ENABLE = 1'b0;
    logic [31:0] iIRQ_REQ = '0;
    logic        iEXT_ACK = 1'b0;
    logic        oEXT_ACTIVE;
    logic [5:0]  oEXT_NUM;
    logic [31:0] oPENDING;

    always #5 iCLOCK = ~iCLOCK;

    external_irq_arbiter #(
        .IRQ_LINES  (32),
        .GAP_CYCLES (2)
    ) dut (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iARB_ENABLE (iARB_ENABLE),
        .iIRQ_REQ    (iIRQ_REQ),
        .oEXT_ACTIVE (oEXT_ACTIVE),
        .oEXT_NUM    (oEXT_NUM),
        .iEXT_ACK    (iEXT_ACK),
        .oPENDING    (oPENDING)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] req;
        logic        ack;
        logic        act;
        logic [5:0]  num;
        logic [31:0] pend;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic rst, input logic en, input logic [31:0] req,
                       input logic ack, input logic act, input logic [5:0] num,
                       input logic [31:0] pend);
        vec_t v;
        v.rst = rst; v.en = en; v.req = req; v.ack = ack;
        v.act = act; v.num = num; v.pend = pend;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, sample 1ns after the edge.
    task automatic cycle(input logic rst, input logic en, input logic [31:0] req, input logic ack);
        iRESET_SYNC = rst;
        iARB_ENABLE = en;
        iIRQ_REQ    = req;
        iEXT_ACK    = ack;
        @(posedge iCLOCK);
        #1;
    endtask

    int   n_pres;
    logic prev_act;

    initial begin
        //  rst en req           ack act num pend
        // single pulse on line 5, ACK two cycles after presentation
        add(1, 1, 32'h0,        0, 0, 0,  32'h0);
        add(0, 1, 32'h20,       0, 0, 0,  32'h20);
        add(0, 1, 32'h0,        0, 1, 5,  32'h20);
        add(0, 1, 32'h0,        0, 1, 5,  32'h20);
        add(0, 1, 32'h0,        1, 0, 5,  32'h0);
        add(0, 1, 32'h0,        0, 0, 5,  32'h0);
        add(0, 1, 32'h0,        0, 0, 5,  32'h0);
        add(0, 1, 32'h0,        0, 0, 5,  32'h0);
        // lines 3, 7, 20 together -> order 3, 7, 20
        add(1, 1, 32'h0,        0, 0, 0,  32'h0);
        add(0, 1, 32'h00100088, 0, 0, 0,  32'h00100088);
        add(0, 1, 32'h0,        0, 1, 3,  32'h00100088);
        add(0, 1, 32'h0,        1, 0, 3,  32'h00100080);
        add(0, 1, 32'h0,        0, 0, 3,  32'h00100080);
        add(0, 1, 32'h0,        0, 0, 3,  32'h00100080);
        add(0, 1, 32'h0,        0, 1, 7,  32'h00100080);
        add(0, 1, 32'h0,        1, 0, 7,  32'h00100000);
        add(0, 1, 32'h0,        0, 0, 7,  32'h00100000);
        add(0, 1, 32'h0,        0, 0, 7,  32'h00100000);
        add(0, 1, 32'h0,        0, 1, 20, 32'h00100000);
        add(0, 1, 32'h0,        1, 0, 20, 32'h0);
        add(0, 1, 32'h0,        0, 0, 20, 32'h0);
        add(0, 1, 32'h0,        0, 0, 20, 32'h0);
        // pointer now 21: lines 20 and 22 -> 22 first, then 20
        add(0, 1, 32'h00500000, 0, 0, 20, 32'h00500000);
        add(0, 1, 32'h0,        0, 1, 22, 32'h00500000);
        add(0, 1, 32'h0,        1, 0, 22, 32'h00100000);
        add(0, 1, 32'h0,        0, 0, 22, 32'h00100000);
        add(0, 1, 32'h0,        0, 0, 22, 32'h00100000);
        add(0, 1, 32'h0,        0, 1, 20, 32'h00100000);
        add(0, 1, 32'h0,        1, 0, 20, 32'h0);
        add(0, 1, 32'h0,        0, 0, 20, 32'h0);
        add(0, 1, 32'h0,        0, 0, 20, 32'h0);
        // pointer to 8 via line 7, then lines 2 and 10 -> 10, then 2
        add(1, 1, 32'h0,        0, 0, 0,  32'h0);
        add(0, 1, 32'h80,       0, 0, 0,  32'h80);
        add(0, 1, 32'h0,        0, 1, 7,  32'h80);
        add(0, 1, 32'h0,        1, 0, 7,  32'h0);
        add(0, 1, 32'h404,      0, 0, 7,  32'h404);
        add(0, 1, 32'h0,        0, 0, 7,  32'h404);
        add(0, 1, 32'h0,        0, 1, 10, 32'h404);
        add(0, 1, 32'h0,        1, 0, 10, 32'h4);
        add(0, 1, 32'h0,        0, 0, 10, 32'h4);
        add(0, 1, 32'h0,        0, 0, 10, 32'h4);
        add(0, 1, 32'h0,        0, 1, 2,  32'h4);
        add(0, 1, 32'h0,        1, 0, 2,  32'h0);
        add(0, 1, 32'h0,        0, 0, 2,  32'h0);
        add(0, 1, 32'h0,        0, 0, 2,  32'h0);
        // enable low holds off lines 1 and 4; dropping enable keeps PRESENT
        add(1, 0, 32'h0,        0, 0, 0,  32'h0);
        add(0, 0, 32'h12,       0, 0, 0,  32'h12);
        add(0, 0, 32'h0,        0, 0, 0,  32'h12);
        add(0, 0, 32'h0,        0, 0, 0,  32'h12);
        add(0, 1, 32'h0,        0, 1, 1,  32'h12);
        add(0, 0, 32'h0,        0, 1, 1,  32'h12);
        add(0, 0, 32'h0,        0, 1, 1,  32'h12);
        add(0, 0, 32'h0,        1, 0, 1,  32'h10);
        add(0, 0, 32'h0,        0, 0, 1,  32'h10);
        add(0, 0, 32'h0,        0, 0, 1,  32'h10);
        add(0, 0, 32'h0,        0, 0, 1,  32'h10);
        add(0, 1, 32'h0,        0, 1, 4,  32'h10);
        add(0, 1, 32'h0,        1, 0, 4,  32'h0);
        add(0, 1, 32'h0,        0, 0, 4,  32'h0);
        add(0, 1, 32'h0,        0, 0, 4,  32'h0);
        add(0, 1, 32'h0,        0, 0, 4,  32'h0);
        // reset during PRESENT of line 9; line 3 held through reset
        add(0, 1, 32'h200,      0, 0, 4,  32'h200);
        add(0, 1, 32'h0,        0, 1, 9,  32'h200);
        add(1, 1, 32'h8,        0, 0, 0,  32'h0);
        add(0, 1, 32'h208,      0, 0, 0,  32'h208);
        add(0, 1, 32'h208,      0, 1, 3,  32'h208);
        add(0, 1, 32'h208,      1, 0, 3,  32'h200);
        add(0, 1, 32'h208,      1, 0, 3,  32'h200);
        add(0, 1, 32'h208,      0, 0, 3,  32'h200);
        add(0, 1, 32'h208,      0, 1, 9,  32'h200);
        add(0, 1, 32'h208,      1, 0, 9,  32'h0);
        add(0, 1, 32'h208,      0, 0, 9,  32'h0);
        add(0, 1, 32'h208,      0, 0, 9,  32'h0);
        // stray ACK in IDLE must not touch pending line 6
        add(0, 0, 32'h40,       1, 0, 9,  32'h40);
        add(0, 0, 32'h0,        1, 0, 9,  32'h40);
        add(0, 1, 32'h0,        0, 1, 6,  32'h40);
        add(0, 1, 32'h0,        1, 0, 6,  32'h0);
        add(0, 1, 32'h0,        0, 0, 6,  32'h0);
        add(0, 1, 32'h0,        0, 0, 6,  32'h0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].ack);
            check($sformatf("v%0d active", i), 32'(oEXT_ACTIVE), 32'(vecs[i].act));
            check($sformatf("v%0d num", i),    32'(oEXT_NUM),    32'(vecs[i].num));
            check($sformatf("v%0d pending", i), oPENDING,        vecs[i].pend);
        end

        // line 31 held high for 50 cycles: one presentation only
        cycle(1, 1, 32'h0, 0);
        check("held reset active", 32'(oEXT_ACTIVE), 32'd0);
        n_pres   = 0;
        prev_act = 1'b0;
        for (int c = 0; c < 50; c++) begin
            cycle(0, 1, 32'h80000000, oEXT_ACTIVE);
            if (oEXT_ACTIVE && !prev_act) begin
                n_pres++;
                check("held num", 32'(oEXT_NUM), 32'd31);
            end
            prev_act = oEXT_ACTIVE;
        end
        check("held presentations", 32'(n_pres), 32'd1);
        check("held pending", oPENDING, 32'h0);
        cycle(0, 1, 32'h0, 0);
        cycle(0, 1, 32'h0, 0);
        check("release active", 32'(oEXT_ACTIVE), 32'd0);

        // line 31 re-pulsed in its ACK cycle: set wins, re-presented after gap
        cycle(0, 1, 32'h80000000, 0);
        check("repulse pend", oPENDING, 32'h80000000);
        cycle(0, 1, 32'h0, 0);
        check("repulse present", 32'(oEXT_ACTIVE), 32'd1);
        check("repulse num", 32'(oEXT_NUM), 32'd31);
        cycle(0, 1, 32'h80000000, 1);
        check("repulse ack active", 32'(oEXT_ACTIVE), 32'd0);
        check("repulse ack pend", oPENDING, 32'h80000000);
        cycle(0, 1, 32'h0, 0);
        check("repulse gap1", 32'(oEXT_ACTIVE), 32'd0);
        cycle(0, 1, 32'h0, 0);
        check("repulse gap2", 32'(oEXT_ACTIVE), 32'd0);
        cycle(0, 1, 32'h0, 0);
        check("repulse again active", 32'(oEXT_ACTIVE), 32'd1);
        check("repulse again num", 32'(oEXT_NUM), 32'd31);
        cycle(0, 1, 32'h0, 1);
        check("repulse final pend", oPENDING, 32'h0);
        check("repulse final active", 32'(oEXT_ACTIVE), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
